mem_arbiter: RTL and testbench

- N-requester front end for the single-port line memory. Sits between the core's cache miss ports (I$, D$, later extra agents) and the memory model.
- Arbitrates requests round-robin and allows one outstanding line transaction at a time.
- Routes each fill back to the requester that issued it. Flags protocol errors (address mismatch, spurious fill, timeout).

---
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin N-port front end for the single-port line memory
//
// Grants one upstream cache-miss port at a time, forwards its line read or
// eviction write to memory, and routes the completion back to that port.
// Only one line transaction is outstanding at any time.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   up_req/up_store   per-port request level and store flag (1 = eviction write)
//   up_addr/up_data   per-port line address / eviction data, port p at [p*W +: W]
//   up_fill           one-hot, one-cycle completion pulse to the owning port
//   up_fill_data/addr broadcast fill line and address, valid while up_fill != 0
//   mem_req/store     downstream request level and store flag
//   mem_addr/data     downstream address and eviction data
//   mem_fill          memory completion pulse (loads and stores)
//   mem_fill_data/addr returned line and address
//   err_status        sticky: [0] addr mismatch, [1] spurious fill, [2] timeout

module mem_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             up_req,
    input  logic [NUM_PORTS-1:0]             up_store,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  up_addr,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0]  up_data,
    output logic [NUM_PORTS-1:0]             up_fill,
    output logic [LINE_WIDTH-1:0]            up_fill_data,
    output logic [ADDR_WIDTH-1:0]            up_fill_addr,
    output logic                             mem_req,
    output logic                             mem_store,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [LINE_WIDTH-1:0]            mem_data,
    input  logic                             mem_fill,
    input  logic [LINE_WIDTH-1:0]            mem_fill_data,
    input  logic [ADDR_WIDTH-1:0]            mem_fill_addr,
    output logic [2:0]                       err_status
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYCLES);
    localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [PW-1:0]          rr_ptr_q;
    logic [PW-1:0]          owner_q;
    logic                   store_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [LINE_WIDTH-1:0]  data_q;
    logic [LINE_WIDTH-1:0]  fill_data_q;
    logic [ADDR_WIDTH-1:0]  fill_addr_q;
    logic [2:0]             err_q;
    logic [TW-1:0]          tmo_cnt_q;

    logic                   grant_valid;
    logic [PW-1:0]          grant_idx;

    // Cyclic search for the first requester at or after rr_ptr. The candidate
    // index wraps explicitly so non-power-of-two port counts never land on a
    // nonexistent port.
    always_comb begin
        int cand;
        cand        = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            if (!grant_valid && up_req[PW'(cand)]) begin
                grant_valid = 1'b1;
                grant_idx   = PW'(cand);
            end
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        up_fill = '0;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                mem_req = 1'b1;
                if (mem_fill) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                up_fill[owner_q] = 1'b1;
                state_d          = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Transaction datapath, round-robin pointer, error flags and watchdog.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            store_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            fill_data_q <= '0;
            fill_addr_q <= '0;
            err_q       <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner_q   <= grant_idx;
                        store_q   <= up_store[grant_idx];
                        addr_q    <= up_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        data_q    <= up_data[grant_idx*LINE_WIDTH +: LINE_WIDTH];
                        tmo_cnt_q <= '0;
                    end
                    if (mem_fill) begin
                        err_q[1] <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (mem_fill) begin
                        fill_data_q <= mem_fill_data;
                        fill_addr_q <= mem_fill_addr;
                        // A mismatched fill is still delivered; it is only flagged.
                        if (mem_fill_addr != addr_q) begin
                            err_q[0] <= 1'b1;
                        end
                    end else if (WDOG_EN && (tmo_cnt_q != TMO_MAX)) begin
                        // Saturating count; the FSM never aborts, it only flags.
                        tmo_cnt_q <= tmo_cnt_q + TW'(1);
                        if ((tmo_cnt_q + TW'(1)) == TMO_MAX) begin
                            err_q[2] <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    rr_ptr_q <= (owner_q == LAST_PORT) ? '0 : owner_q + 1'b1;
                    if (mem_fill) begin
                        err_q[1] <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_store    = store_q;
    assign mem_addr     = addr_q;
    assign mem_data     = data_q;
    assign up_fill_data = fill_data_q;
    assign up_fill_addr = fill_addr_q;
    assign err_status   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter

module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int LW  = 128;
    localparam int BLW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance A: 2 ports, watchdog at 8 cycles
    logic              a_reset;
    logic [1:0]        a_req, a_store, a_fill;
    logic [2*AW-1:0]   a_addr;
    logic [2*LW-1:0]   a_data;
    logic [LW-1:0]     a_fdata, a_mdata, a_mfdata;
    logic [AW-1:0]     a_faddr, a_maddr, a_mfaddr;
    logic              a_mreq, a_mstore, a_mfill;
    logic [2:0]        a_err;

    // Instance B: 3 ports, no watchdog
    logic              b_reset;
    logic [2:0]        b_req, b_store, b_fill;
    logic [3*AW-1:0]   b_addr;
    logic [3*BLW-1:0]  b_data;
    logic [BLW-1:0]    b_fdata, b_mdata, b_mfdata;
    logic [AW-1:0]     b_faddr, b_maddr, b_mfaddr;
    logic              b_mreq, b_mstore, b_mfill;
    logic [2:0]        b_err;

    mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(8)) u_dut_a (
        .clk(clk), .reset(a_reset),
        .up_req(a_req), .up_store(a_store), .up_addr(a_addr), .up_data(a_data),
        .up_fill(a_fill), .up_fill_data(a_fdata), .up_fill_addr(a_faddr),
        .mem_req(a_mreq), .mem_store(a_mstore), .mem_addr(a_maddr), .mem_data(a_mdata),
        .mem_fill(a_mfill), .mem_fill_data(a_mfdata), .mem_fill_addr(a_mfaddr),
        .err_status(a_err)
    );

    mem_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(AW), .LINE_WIDTH(BLW), .TIMEOUT_CYCLES(0)) u_dut_b (
        .clk(clk), .reset(b_reset),
        .up_req(b_req), .up_store(b_store), .up_addr(b_addr), .up_data(b_data),
        .up_fill(b_fill), .up_fill_data(b_fdata), .up_fill_addr(b_faddr),
        .mem_req(b_mreq), .mem_store(b_mstore), .mem_addr(b_maddr), .mem_data(b_mdata),
        .mem_fill(b_mfill), .mem_fill_data(b_mfdata), .mem_fill_addr(b_mfaddr),
        .err_status(b_err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    int n;
    int a_ord [4] = '{0, 1, 0, 1};
    int b_ord [4] = '{2, 0, 1, 2};
    logic [AW-1:0] exp_addr;

    initial begin
        a_reset = 1'b0; a_req = '0; a_store = '0; a_addr = '0; a_data = '0;
        a_mfill = 1'b0; a_mfdata = '0; a_mfaddr = '0;
        b_reset = 1'b0; b_req = '0; b_store = '0; b_addr = '0; b_data = '0;
        b_mfill = 1'b0; b_mfdata = '0; b_mfaddr = '0;
        tick(); tick();

        // Reset state
        chk("rst_mem_req", a_mreq, 1'b0);
        chk("rst_up_fill", a_fill, 2'b00);
        chk("rst_err", a_err, 3'b000);
        chk("rst_mem_addr", a_maddr, 32'h0);
        chk("rst_mem_data", a_mdata, 128'h0);
        chk("rst_fill_data", a_fdata, 128'h0);
        chk("rst_fill_addr", a_faddr, 32'h0);
        chk("rst_mem_store", a_mstore, 1'b0);
        a_reset = 1'b1;
        b_reset = 1'b1;
        tick();

        // Single read on port 0, memory fills 5 cycles into WAIT
        a_req = 2'b01; a_store = 2'b00; a_addr = {32'h0, 32'h100};
        tick();
        chk("t1_mem_req", a_mreq, 1'b1);
        chk("t1_mem_addr", a_maddr, 32'h100);
        chk("t1_mem_store", a_mstore, 1'b0);
        tick(); tick(); tick(); tick();
        chk("t1_still_waiting", a_mreq, 1'b1);
        a_mfill = 1'b1; a_mfdata = 128'h0DEADBEEF0; a_mfaddr = 32'h100;
        tick();
        a_mfill = 1'b0;
        chk("t1_up_fill", a_fill, 2'b01);
        chk("t1_fill_data", a_fdata, 128'h0DEADBEEF0);
        chk("t1_fill_addr", a_faddr, 32'h100);
        chk("t1_mem_req_low", a_mreq, 1'b0);
        a_req = 2'b00;
        tick();
        chk("t1_fill_pulse_end", a_fill, 2'b00);
        chk("t1_err", a_err, 3'b000);

        // Both ports from reset, held continuously: p0, p1, p0, p1
        a_reset = 1'b0; tick(); a_reset = 1'b1; tick();
        a_req = 2'b11; a_addr = {32'h80, 32'h40};
        for (int k = 0; k < 4; k++) begin
            exp_addr = (a_ord[k] == 0) ? 32'h40 : 32'h80;
            n = (k == 0) ? 0 : 1;
            do begin tick(); n++; end while (a_mreq !== 1'b1 && n < 20);
            chk($sformatf("t2_req_spacing_%0d", k), n, (k == 0) ? 1 : 3);
            chk($sformatf("t2_mem_addr_%0d", k), a_maddr, exp_addr);
            a_mfill = 1'b1; a_mfaddr = exp_addr; a_mfdata = 128'h1000 + 128'(k);
            tick();
            a_mfill = 1'b0;
            chk($sformatf("t2_up_fill_%0d", k), a_fill, 2'b01 << a_ord[k]);
            chk($sformatf("t2_fill_data_%0d", k), a_fdata, 128'h1000 + 128'(k));
        end
        a_req = 2'b00;
        tick();

        // Eviction on port 1
        a_req = 2'b10; a_store = 2'b10; a_addr = {32'h200, 32'h0};
        a_data = {{16{8'hA5}}, 128'h0};
        tick();
        chk("t3_mem_req", a_mreq, 1'b1);
        chk("t3_mem_store", a_mstore, 1'b1);
        chk("t3_mem_addr", a_maddr, 32'h200);
        chk("t3_mem_data", a_mdata, {16{8'hA5}});
        a_mfill = 1'b1; a_mfaddr = 32'h200; a_mfdata = '0;
        tick();
        a_mfill = 1'b0;
        chk("t3_up_fill", a_fill, 2'b10);
        a_req = 2'b00; a_store = 2'b00;
        tick();
        chk("t3_err", a_err, 3'b000);

        // Address mismatch, then a spurious fill in IDLE
        a_req = 2'b01; a_addr = {32'h0, 32'h100};
        tick();
        chk("t4_mem_addr", a_maddr, 32'h100);
        a_mfill = 1'b1; a_mfaddr = 32'h104; a_mfdata = 128'h55;
        tick();
        a_mfill = 1'b0;
        chk("t4_up_fill", a_fill, 2'b01);
        chk("t4_fill_addr", a_faddr, 32'h104);
        chk("t4_fill_data", a_fdata, 128'h55);
        chk("t4_err_mismatch", a_err, 3'b001);
        a_req = 2'b00;
        tick();
        a_mfill = 1'b1; a_mfaddr = 32'h0;
        tick();
        a_mfill = 1'b0;
        chk("t4_spur_no_fill", a_fill, 2'b00);
        chk("t4_err_spurious", a_err, 3'b011);
        chk("t4_spur_no_req", a_mreq, 1'b0);

        // Watchdog: memory never fills
        a_reset = 1'b0; tick(); a_reset = 1'b1; tick();
        chk("t5_err_cleared", a_err, 3'b000);
        a_req = 2'b01; a_addr = {32'h0, 32'h300};
        tick();
        chk("t5_mem_req", a_mreq, 1'b1);
        for (int i = 1; i < 8; i++) tick();
        chk("t5_err_before", a_err, 3'b000);
        tick();
        chk("t5_err_timeout", a_err, 3'b100);
        chk("t5_mem_req_held", a_mreq, 1'b1);
        tick(); tick(); tick();
        chk("t5_still_waiting", a_mreq, 1'b1);
        chk("t5_err_sticky", a_err, 3'b100);
        a_reset = 1'b0;
        #1;
        chk("t5_rst_mem_req", a_mreq, 1'b0);
        chk("t5_rst_err", a_err, 3'b000);
        chk("t5_rst_mem_addr", a_maddr, 32'h0);
        chk("t5_rst_up_fill", a_fill, 2'b00);
        a_req = 2'b00;
        tick();
        a_reset = 1'b1;
        tick(); tick();
        chk("t5_idle_after_rst", a_mreq, 1'b0);

        // 3 ports: move rr_ptr to 2 with a single port-1 transaction
        b_addr = {32'h12, 32'h11, 32'h10};
        b_req = 3'b010;
        tick();
        chk("t6_mem_addr_p1", b_maddr, 32'h11);
        b_mfill = 1'b1; b_mfaddr = 32'h11; b_mfdata = 32'hCAFE;
        tick();
        b_mfill = 1'b0;
        chk("t6_up_fill_p1", b_fill, 3'b010);
        b_req = 3'b000;
        tick();

        // All three requesting from rr_ptr=2: p2, p0, p1, p2
        b_req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            exp_addr = 32'h10 + 32'(b_ord[k]);
            n = (k == 0) ? 0 : 1;
            do begin tick(); n++; end while (b_mreq !== 1'b1 && n < 20);
            chk($sformatf("t6_req_spacing_%0d", k), n, (k == 0) ? 1 : 3);
            chk($sformatf("t6_mem_addr_%0d", k), b_maddr, exp_addr);
            if (k < 3) begin
                b_mfill = 1'b1; b_mfaddr = exp_addr; b_mfdata = 32'hB000 + 32'(k);
                tick();
                b_mfill = 1'b0;
                chk($sformatf("t6_up_fill_%0d", k), b_fill, 3'b001 << b_ord[k]);
                chk($sformatf("t6_fill_data_%0d", k), b_fdata, 32'hB000 + 32'(k));
            end
        end

        // Reset while p2 is in WAIT
        b_reset = 1'b0;
        #1;
        chk("t7_rst_mem_req", b_mreq, 1'b0);
        chk("t7_rst_up_fill", b_fill, 3'b000);
        tick();
        chk("t7_no_fill_later", b_fill, 3'b000);
        b_req = 3'b000;
        tick();
        b_reset = 1'b1;
        tick(); tick();
        chk("t7_no_fill_after", b_fill, 3'b000);
        chk("t7_idle_after", b_mreq, 1'b0);
        chk("t7_err", b_err, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
